// File: rtl/fib_seq_gen.sv
// Fibonacci-class sequence engine (standard, Lucas, user-seeded), optionally modulo
// a runtime modulus, streaming terms over a valid/ready interface.
module fib_seq_gen #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] seed0,
  input  logic [WIDTH-1:0] seed1,
  input  logic [CNT_W-1:0] n_terms,
  input  logic             mod_en,
  input  logic [WIDTH-1:0] mod_val,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] out_idx,
  output logic             out_last,
  output logic             busy,
  output logic             done,
  output logic             ovf
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a, b, seed_a, seed_b, nxt, mval_r;
  logic [WIDTH:0]   sum;
  logic [CNT_W-1:0] idx, n_reg;
  logic             modm_r, b_ovf;
  logic             fire, load, zero_done, adv, fin, cnt_last;

  // (a,b) = (current, next); b_ovf marks that b carried out, making a the last term
  assign out_valid = (state == S_RUN);
  assign busy      = out_valid;
  assign out_data  = a;
  assign out_idx   = idx;
  assign cnt_last  = (idx == n_reg - CNT_W'(1));
  assign out_last  = out_valid && (cnt_last || b_ovf);
  assign fire      = out_valid && out_ready;
  assign sum       = {1'b0, a} + {1'b0, b};

  always_comb begin
    seed_a = '0;
    seed_b = WIDTH'(1);
    case (mode)
      2'b01: seed_a = WIDTH'(2);
      2'b10: begin
        seed_a = seed0;
        seed_b = seed1;
      end
      default: ;
    endcase
  end

  always_comb begin
    nxt = sum[WIDTH-1:0];
    if (modm_r && (sum >= {1'b0, mval_r}))
      nxt = WIDTH'(sum - {1'b0, mval_r});
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    zero_done = 1'b0;
    adv       = 1'b0;
    fin       = 1'b0;
    if (abort) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_RUN: begin
          if (fire) begin
            if (out_last) begin
              fin       = 1'b1;
              state_nxt = S_DONE;
            end else begin
              adv = 1'b1;
            end
          end
        end
        default: begin
          state_nxt = S_IDLE;
          if (start) begin
            if (n_terms == '0) begin
              zero_done = 1'b1;
            end else begin
              load      = 1'b1;
              state_nxt = S_RUN;
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a      <= '0;
      b      <= '0;
      idx    <= '0;
      n_reg  <= '0;
      mval_r <= '0;
      modm_r <= 1'b0;
      b_ovf  <= 1'b0;
      done   <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      done <= zero_done || fin;
      if (load || zero_done)
        ovf <= 1'b0;
      if (load) begin
        a      <= seed_a;
        b      <= seed_b;
        idx    <= '0;
        n_reg  <= n_terms;
        mval_r <= mod_val;
        modm_r <= mod_en && (mod_val != '0);
        b_ovf  <= 1'b0;
      end
      if (adv) begin
        a     <= b;
        b     <= nxt;
        idx   <= idx + CNT_W'(1);
        b_ovf <= sum[WIDTH] && !modm_r;
      end
      if (fin && b_ovf && !cnt_last)
        ovf <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fib_seq_gen.sv
// Scoreboard bench for fib_seq_gen at WIDTH=8: an independent integer model fills
// the expected queue, observed transfers are queued and compared per scenario.
module tb_fib_seq_gen;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0, abort = 1'b0, mod_en = 1'b0, out_ready = 1'b1;
  logic [1:0] mode = 2'b00;
  logic [7:0] seed0 = '0, seed1 = '0, n_terms = '0, mod_val = '0;
  logic       out_valid, out_last, busy, done, ovf;
  logic [7:0] out_data, out_idx;

  fib_seq_gen #(.WIDTH(8), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .mode(mode),
    .seed0(seed0), .seed1(seed1), .n_terms(n_terms), .mod_en(mod_en),
    .mod_val(mod_val), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_idx(out_idx), .out_last(out_last),
    .busy(busy), .done(done), .ovf(ovf)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] data;
    logic [7:0] idx;
    logic       last;
  } term_t;

  term_t      exp_q[$], obs_q[$];
  logic [7:0] hold_d[$], hold_i[$];
  int         checks = 0, passes = 0;
  int         cycles;
  bit         done_seen, ovf_at_done;

  task automatic model_push(input int md, input int s0, input int s1, input int n,
                            input bit me, input int mv, output bit eovf);
    int a, b, c;
    bit modm, last;
    term_t t;
    modm = me && (mv != 0);
    case (md)
      1:       begin a = 2;  b = 1;  end
      2:       begin a = s0; b = s1; end
      default: begin a = 0;  b = 1;  end
    endcase
    eovf = 1'b0;
    for (int i = 0; i < n; i++) begin
      last   = (i == n - 1) || (!modm && b > 255);
      t.data = 8'(a);
      t.idx  = 8'(i);
      t.last = last;
      exp_q.push_back(t);
      if (last) begin
        eovf = (i < n - 1);
        break;
      end
      c = a + b;
      if (modm && c >= mv) c = c - mv;
      a = b;
      b = c;
    end
  endtask

  // called at a negedge; config inputs are scrambled afterwards as they must be ignored
  task automatic drive_start(input int md, input int s0, input int s1, input int n,
                             input bit me, input int mv);
    mode    = 2'(md);
    seed0   = 8'(s0);
    seed1   = 8'(s1);
    n_terms = 8'(n);
    mod_en  = me;
    mod_val = 8'(mv);
    start   = 1'b1;
    @(negedge clk);
    start   = 1'b0;
    mode    = 2'b01;
    seed0   = 8'hAA;
    seed1   = 8'h55;
    n_terms = 8'd255;
    mod_en  = ~me;
    mod_val = 8'd3;
  endtask

  task automatic capture(input int stall_idx, input int stall_len, input int poke_idx);
    int sl;
    term_t t;
    sl = stall_len;
    obs_q.delete();
    hold_d.delete();
    hold_i.delete();
    done_seen = 1'b0;
    ovf_at_done = 1'b0;
    cycles = 0;
    for (int k = 0; k < 300; k++) begin
      if (sl > 0 && out_valid && out_idx == 8'(stall_idx)) begin
        out_ready = 1'b0;
        sl--;
        hold_d.push_back(out_data);
        hold_i.push_back(out_idx);
      end else begin
        out_ready = 1'b1;
      end
      start = (poke_idx >= 0 && out_valid && out_idx == 8'(poke_idx));
      if (done) begin
        done_seen = 1'b1;
        ovf_at_done = ovf;
        break;
      end
      if (out_valid && out_ready) begin
        t.data = out_data;
        t.idx  = out_idx;
        t.last = out_last;
        obs_q.push_back(t);
      end
      cycles++;
      @(negedge clk);
    end
    out_ready = 1'b1;
    start = 1'b0;
  endtask

  task automatic test_sequence(input string name, input int md, input int s0, input int s1,
                               input int n, input bit me, input int mv,
                               input int stall_idx, input int stall_len, input int poke_idx,
                               input bit no_lead, input bit no_tail);
    bit eovf;
    int nexp, nmin;
    term_t e;
    exp_q.delete();
    model_push(md, s0, s1, n, me, mv, eovf);
    nexp = exp_q.size();
    if (!no_lead) @(negedge clk);
    drive_start(md, s0, s1, n, me, mv);
    capture(stall_idx, stall_len, poke_idx);
    checks++;
    if (!done_seen) $display("FAIL %s done_timeout: no done within budget", name);
    else passes++;
    checks++;
    if (obs_q.size() !== nexp) $display("FAIL %s count: got %0d terms, expected %0d", name, obs_q.size(), nexp);
    else passes++;
    nmin = (obs_q.size() < nexp) ? obs_q.size() : nexp;
    for (int i = 0; i < nmin; i++) begin
      e = exp_q[i];
      checks++;
      if (obs_q[i] !== e)
        $display("FAIL %s term%0d: got data=%0d idx=%0d last=%0b, expected data=%0d idx=%0d last=%0b",
                 name, i, obs_q[i].data, obs_q[i].idx, obs_q[i].last, e.data, e.idx, e.last);
      else passes++;
    end
    checks++;
    if (cycles !== nexp + stall_len) $display("FAIL %s latency: done after %0d cycles, expected %0d", name, cycles, nexp + stall_len);
    else passes++;
    checks++;
    if (ovf_at_done !== eovf) $display("FAIL %s ovf: got %0b, expected %0b", name, ovf_at_done, eovf);
    else passes++;
    if (stall_len > 0) begin
      checks++;
      if (hold_d.size() !== stall_len) $display("FAIL %s stall_len: got %0d, expected %0d", name, hold_d.size(), stall_len);
      else passes++;
      for (int i = 0; i < hold_d.size(); i++) begin
        e = exp_q[stall_idx];
        checks++;
        if (hold_d[i] !== e.data || hold_i[i] !== e.idx)
          $display("FAIL %s hold%0d: got data=%0d idx=%0d, expected data=%0d idx=%0d", name, i, hold_d[i], hold_i[i], e.data, e.idx);
        else passes++;
      end
    end
    if (!no_tail) begin
      @(negedge clk);
      checks++;
      if ({done, busy, out_valid} !== 3'b000) $display("FAIL %s post_done: got done/busy/valid=%b, expected 000", name, {done, busy, out_valid});
      else passes++;
    end
  endtask

  task automatic test_reset;
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({out_valid, out_data, out_idx, out_last, busy, done, ovf} !== '0)
      $display("FAIL reset_state: got valid=%b data=%0d idx=%0d last=%b busy=%b done=%b ovf=%b, expected all 0",
               out_valid, out_data, out_idx, out_last, busy, done, ovf);
    else passes++;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_ovf_sticky;
    repeat (2) @(negedge clk);
    checks++;
    if (ovf !== 1'b1) $display("FAIL ovf_sticky: got %b, expected 1", ovf);
    else passes++;
  endtask

  task automatic test_back_to_back;
    @(negedge clk);
    test_sequence("b2b_a", 1, 0, 0, 3, 1'b0, 0, -1, 0, -1, 1'b1, 1'b1);
    test_sequence("b2b_b", 2, 9, 4, 5, 1'b0, 0, -1, 0, -1, 1'b1, 1'b0);
  endtask

  task automatic test_abort;
    int seen;
    @(negedge clk);
    drive_start(0, 0, 0, 10, 1'b0, 0);
    for (int k = 0; k < 50 && !(out_valid && out_idx == 8'd6); k++) @(negedge clk);
    checks++;
    if (out_idx !== 8'd6) $display("FAIL abort_reach: got idx %0d, expected 6", out_idx);
    else passes++;
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checks++;
    if ({out_valid, busy, done} !== 3'b000) $display("FAIL abort_exit: got valid/busy/done=%b, expected 000", {out_valid, busy, done});
    else passes++;
    seen = 0;
    repeat (4) begin
      @(negedge clk);
      if (done || out_valid) seen++;
    end
    checks++;
    if (seen !== 0) $display("FAIL abort_quiet: got %0d cycles with done/valid, expected 0", seen);
    else passes++;
  endtask

  task automatic test_reset_midrun;
    @(negedge clk);
    drive_start(0, 0, 0, 10, 1'b0, 0);
    for (int k = 0; k < 50 && !(out_valid && out_idx == 8'd3); k++) @(negedge clk);
    reset = 1'b0;
    #1;
    checks++;
    if ({out_valid, out_data, out_idx, out_last, busy, done, ovf} !== '0)
      $display("FAIL reset_midrun: got valid=%b data=%0d idx=%0d last=%b busy=%b done=%b ovf=%b, expected all 0",
               out_valid, out_data, out_idx, out_last, busy, done, ovf);
    else passes++;
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    test_reset();
    test_sequence("std10",   0, 0, 0, 10, 1'b0, 0,  -1, 0, -1, 1'b0, 1'b0);
    test_sequence("ovf20",   0, 0, 0, 20, 1'b0, 0,  -1, 0, -1, 1'b0, 1'b1);
    test_ovf_sticky();
    test_sequence("ovf14",   0, 0, 0, 14, 1'b0, 0,  -1, 0, -1, 1'b0, 1'b0);
    test_sequence("lucas5",  1, 0, 0, 5,  1'b0, 0,  -1, 0, -1, 1'b0, 1'b0);
    test_sequence("user4",   2, 5, 7, 4,  1'b0, 0,  -1, 0, -1, 1'b0, 1'b0);
    test_sequence("rsvd6",   3, 9, 9, 6,  1'b0, 0,  -1, 0, -1, 1'b0, 1'b0);
    test_sequence("mod10",   0, 0, 0, 12, 1'b1, 10, -1, 0, -1, 1'b0, 1'b0);
    test_sequence("mod0",    0, 0, 0, 12, 1'b1, 0,  -1, 0, -1, 1'b0, 1'b0);
    test_sequence("modbig",  2, 200, 150, 30, 1'b1, 251, -1, 0, -1, 1'b0, 1'b0);
    test_sequence("stall",   0, 0, 0, 10, 1'b0, 0,  4, 3, -1, 1'b0, 1'b0);
    test_sequence("ign_start", 0, 0, 0, 10, 1'b0, 0, -1, 0, 2, 1'b0, 1'b0);
    test_sequence("zero",    0, 0, 0, 0,  1'b0, 0,  -1, 0, -1, 1'b0, 1'b0);
    test_back_to_back();
    test_abort();
    test_reset_midrun();
    test_sequence("restart", 0, 0, 0, 10, 1'b0, 0,  -1, 0, -1, 1'b0, 1'b0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
